// File: rtl/seq_8.sv
// Programmable 8-bit serial sequence detector: load a pattern MSB first, then pulse dout on each match.
// Optional macro SEQ8_OVERLAP_EN keeps the history after a match so overlapping matches are reported.
module seq_8 (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] CNT_FULL = 4'd8;

  logic [7:0] pat_q, pat_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       pvalid_q, pvalid_d;
  logic [7:0] hist_q, hist_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic       dout_q, dout_d;
  logic       load_prev_q;

  logic [7:0] cand;
  logic [3:0] pcnt_base, pcnt_inc, hcnt_inc;
  logic       load_entry, match;

  assign cand       = {hist_q[6:0], din};
  assign load_entry = load && !load_prev_q;
  // A fresh burst counts from zero regardless of any earlier partial or full load.
  assign pcnt_base  = load_entry ? 4'd0 : pcnt_q;
  assign pcnt_inc   = (pcnt_base >= CNT_FULL) ? CNT_FULL : pcnt_base + 4'd1;
  assign hcnt_inc   = (hcnt_q >= CNT_FULL) ? CNT_FULL : hcnt_q + 4'd1;
  assign match      = pvalid_q && (hcnt_q >= 4'd7) && (cand == pat_q);

  always_comb begin
    pat_d    = pat_q;
    pcnt_d   = pcnt_q;
    pvalid_d = pvalid_q;
    hist_d   = hist_q;
    hcnt_d   = hcnt_q;
    dout_d   = 1'b0;
    if (load) begin
      pat_d    = {pat_q[6:0], din};
      pcnt_d   = pcnt_inc;
      pvalid_d = (pcnt_inc >= CNT_FULL);
      hist_d   = 8'd0;
      hcnt_d   = 4'd0;
    end else begin
      dout_d = match;
      hist_d = cand;
`ifdef SEQ8_OVERLAP_EN
      hcnt_d = hcnt_inc;
`else
      hcnt_d = match ? 4'd0 : hcnt_inc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q       <= 8'd0;
      pcnt_q      <= 4'd0;
      pvalid_q    <= 1'b0;
      hist_q      <= 8'd0;
      hcnt_q      <= 4'd0;
      dout_q      <= 1'b0;
      load_prev_q <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      pcnt_q      <= pcnt_d;
      pvalid_q    <= pvalid_d;
      hist_q      <= hist_d;
      hcnt_q      <= hcnt_d;
      dout_q      <= dout_d;
      load_prev_q <= load;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_seq_8.sv
// Directed bench for seq_8: hand-computed dout expectations per clock, checked with immediate assertions.
module tb_seq_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic din = 1'b0;
  logic dout;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  seq_8 dut (.clk(clk), .rst_n(rst_n), .load(load), .din(din), .dout(dout));

  task automatic step(input logic l, input logic d);
    @(negedge clk);
    load = l;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic exp);
    total++;
    assert (dout === exp) passed++;
    else $error("FAIL %s: dout=%b expected=%b", tag, dout, exp);
  endtask

  task automatic load_bits(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i]);
      chk(tag, 1'b0);
    end
  endtask

  // exp[i] is the dout expected after the edge that samples bits[i] (MSB streamed first).
  task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, bits[i]);
      chk(tag, exp[i]);
    end
  endtask

  initial begin
    // reset with load/din active: reset must win
    step(1'b1, 1'b1);
    chk("reset", 1'b0);
    step(1'b0, 1'b1);
    chk("reset2", 1'b0);
    rst_n = 1'b1;

    // pattern 0xA5, exact match then one trailing bit
    load_bits(16'h00A5, 8, "load_a5");
    stream(16'b1_0100_1010, 16'b0_0000_0010, 9, "det_a5");

    // pattern 0xAA on 1010101010
    load_bits(16'h00AA, 8, "load_aa");
`ifdef SEQ8_OVERLAP_EN
    stream(16'b10_1010_1010, 16'b00_0000_0101, 10, "det_aa_ovl");
`else
    stream(16'b10_1010_1010, 16'b00_0000_0100, 10, "det_aa");
`endif

    // short 5-bit load leaves pattern invalid
    load_bits(16'b1_0101, 5, "load_short");
    stream(16'b1010_1010_1010_1010, 16'h0000, 16, "det_short");

    // 0xF0, partial stream, one-cycle load abort -> invalid afterwards
    load_bits(16'h00F0, 8, "load_f0");
    stream(16'b111_1000, 16'h0000, 7, "det_f0_part");
    step(1'b1, 1'b0);
    chk("abort", 1'b0);
    stream(16'b1111_0000, 16'h0000, 8, "det_after_abort");

    // 0x0F, partial stream, reset mid-operation drops the pattern
    load_bits(16'h000F, 8, "load_0f");
    stream(16'b0000, 16'h0000, 4, "det_0f_part");
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    chk("mid_reset", 1'b0);
    rst_n = 1'b1;
    stream(16'b0000_1111, 16'h0000, 8, "det_after_reset");

    // 10-bit load keeps the last 8 bits -> 0x0F
    load_bits(16'b11_0000_1111, 10, "load_10");
    stream(16'b0000_1111, 16'b0000_0001, 8, "det_10");
    stream(16'b0, 16'h0000, 1, "det_10_tail");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
